// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;
    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide on operand magnitudes.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
`ifdef MULDIV_DIV_EN
    input  logic              div_mode,
    output logic [XLEN-1:0]   rem_nxt,
`endif
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [5:0]        cnt,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN:0]     mul_sum;
`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0]   rem;
    logic [XLEN:0]     part;
    logic              qbit;
`endif

    // acc low word starts as the multiplier (or dividend) and is consumed LSB-first (MSB-first for divide)
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        acc_nxt = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        part    = {rem, acc[31]};
        qbit    = (part >= {1'b0, opb});
        rem_nxt = rem;
        if (div_mode) begin
            rem_nxt = qbit ? 32'(part - {1'b0, opb}) : part[31:0];
            acc_nxt = {acc[63:32], acc[30:0], qbit};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            opb <= '0;
            cnt <= '0;
`ifdef MULDIV_DIV_EN
            rem <= '0;
`endif
        end else if (load) begin
            acc <= {32'd0, a_mag};
            opb <= b_mag;
            cnt <= 6'(ITER);
`ifdef MULDIV_DIV_EN
            rem <= '0;
`endif
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - 6'd1;
`ifdef MULDIV_DIV_EN
            rem <= rem_nxt;
`endif
        end
    end
endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage RV32M unit: FSM, operand sign handling, divide special cases and result mux.
// Define MULDIV_DIV_EN for DIV/DIVU/REM/REMU; otherwise divides complete in one cycle with result 0.
module exe_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            busyE,
    output logic            doneE,
    output logic [XLEN-1:0] MulDivResultE
);
    state_t            state;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic              signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, calc_res;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [5:0]        cnt;
    logic              load, step;
`ifdef MULDIV_DIV_EN
    logic              neg_r, div_zero, div_ovf;
    logic [XLEN-1:0]   rem_nxt;
`endif

    assign busyE = (state == CALC) | ((state == IDLE) & startE & ~clear);
    assign load  = (state == IDLE) & startE & ~clear;
    assign step  = (state == CALC) & ~clear;

    assign signed_a = (funct3E == F3_MULH) | (funct3E == F3_MULHSU) |
                      (funct3E == F3_DIV)  | (funct3E == F3_REM);
    assign signed_b = (funct3E == F3_MULH) | (funct3E == F3_DIV) | (funct3E == F3_REM);
    assign a_neg    = signed_a & SrcAE[31];
    assign b_neg    = signed_b & SrcBE[31];
    assign a_mag    = a_neg ? -SrcAE : SrcAE;
    assign b_mag    = b_neg ? -SrcBE : SrcBE;
`ifdef MULDIV_DIV_EN
    assign div_zero = funct3E[2] & (SrcBE == '0);
    assign div_ovf  = funct3E[2] & ~funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == '1);
`endif

    muldiv_iter_core u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
`ifdef MULDIV_DIV_EN
        .div_mode(f3_q[2]),
        .rem_nxt (rem_nxt),
`endif
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .cnt     (cnt),
        .acc_nxt (acc_nxt)
    );

    // Result is taken from the final step's next-state value so it is registered on entry to DONE
    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        case (f3_q)
            F3_MUL:                        calc_res = prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  calc_res = prod[63:32];
`ifdef MULDIV_DIV_EN
            F3_DIV, F3_DIVU:               calc_res = neg_q ? -acc_nxt[31:0] : acc_nxt[31:0];
            F3_REM, F3_REMU:               calc_res = neg_r ? -rem_nxt : rem_nxt;
`endif
            default:                       calc_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            doneE         <= 1'b0;
            MulDivResultE <= '0;
            f3_q          <= '0;
            neg_q         <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_r         <= 1'b0;
`endif
        end else if (clear) begin
            state <= IDLE;
            doneE <= 1'b0;
        end else begin
            case (state)
                IDLE: if (startE) begin
                    f3_q  <= funct3E;
                    neg_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    neg_r <= a_neg;
                    if (div_zero) begin
                        state         <= DONE;
                        doneE         <= 1'b1;
                        MulDivResultE <= funct3E[1] ? SrcAE : '1;
                    end else if (div_ovf) begin
                        state         <= DONE;
                        doneE         <= 1'b1;
                        MulDivResultE <= funct3E[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state <= CALC;
                    end
`else
                    if (funct3E[2]) begin
                        state         <= DONE;
                        doneE         <= 1'b1;
                        MulDivResultE <= '0;
                    end else begin
                        state <= CALC;
                    end
`endif
                end
                CALC: if (cnt == 6'd1) begin
                    state         <= DONE;
                    doneE         <= 1'b1;
                    MulDivResultE <= calc_res;
                end
                // The stalled instruction is still on the inputs here, so startE is not sampled
                DONE: begin
                    state <= IDLE;
                    doneE <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: directed operations, divide special cases, clear and reset.
module tb_exe_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, clear, startE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic        busyE, doneE;
    logic [31:0] MulDivResultE;

    exe_muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .startE       (startE),
        .funct3E      (funct3E),
        .SrcAE        (SrcAE),
        .SrcBE        (SrcBE),
        .busyE        (busyE),
        .doneE        (doneE),
        .MulDivResultE(MulDivResultE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every doneE pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset === 1'b0 && doneE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected doneE", {31'd0, doneE}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, " result"}, MulDivResultE, mon_e.res);
                chk({mon_e.name, " latency"}, cyc - mon_e.t0, mon_e.lat);
            end
        end
    end

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  busy_n;
        bit  seen;
        @(posedge clk); #1;
        funct3E = f3; SrcAE = a; SrcBE = b; startE = 1'b1;
        sb.push_back('{exp, lat, cyc, nm});
        busy_n = 0;
        seen   = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busyE) busy_n++;
            if (doneE) seen = 1;
        end
        if (!seen) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        chk({nm, " busy cycles"}, busy_n, lat);
        chk({nm, " busy in DONE"}, {31'd0, busyE}, 32'd0);
        @(posedge clk); #1;
        startE = 1'b0;
    endtask

    task automatic count_done(input int n, output int d);
        d = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (doneE) d++;
        end
    endtask

    int d;

    initial begin
        reset = 1'b1; clear = 1'b0; startE = 1'b0;
        funct3E = '0; SrcAE = '0; SrcBE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busyE", {31'd0, busyE}, 32'd0);
        chk("reset doneE", {31'd0, doneE}, 32'd0);
        chk("reset result", MulDivResultE, 32'd0);
        reset = 1'b0;

        run_op("MUL 7*-3",        F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULHU -1*-1",     F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULH -1*-1",      F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("MULHSU -1*2",     F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("MULH min*min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("MULHSU min*umax", F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

        repeat (3) @(negedge clk);
        chk("result hold", MulDivResultE, 32'h8000_0000);
        chk("doneE idle", {31'd0, doneE}, 32'd0);

`ifdef MULDIV_DIV_EN
        run_op("DIV -7/2",        F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2",        F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7",      F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7",      F3_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIV 5/0",         F3_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",        F3_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV min/-1",      F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM min/-1",      F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
        run_op("DIV 9/3 off",     F3_DIV,  32'd9, 32'd3, 32'd0, 1);
        run_op("REMU 100/7 off",  F3_REMU, 32'd100, 32'd7, 32'd0, 1);
`endif

        // Flush in the middle of a long operation
        @(posedge clk); #1;
`ifdef MULDIV_DIV_EN
        funct3E = F3_DIV;
`else
        funct3E = F3_MUL;
`endif
        SrcAE = 32'd100; SrcBE = 32'd7; startE = 1'b1;
        repeat (10) @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; startE = 1'b0;
        @(negedge clk);
        chk("clear busyE", {31'd0, busyE}, 32'd0);
        chk("clear doneE", {31'd0, doneE}, 32'd0);
        count_done(40, d);
        chk("clear no done", d, 32'd0);

        // clear beats a start in IDLE
        @(posedge clk); #1;
        funct3E = F3_MUL; SrcAE = 32'd9; SrcBE = 32'd9; startE = 1'b1; clear = 1'b1;
        @(negedge clk);
        chk("clear vs start busyE", {31'd0, busyE}, 32'd0);
        @(posedge clk); #1;
        startE = 1'b0; clear = 1'b0;
        count_done(40, d);
        chk("clear vs start no done", d, 32'd0);

        run_op("MUL 3*4", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset mid-CALC
        @(posedge clk); #1;
        funct3E = F3_MUL; SrcAE = 32'd5; SrcBE = 32'd5; startE = 1'b1;
        repeat (5) @(posedge clk); #1;
        reset = 1'b1; startE = 1'b0;
        #1;
        chk("reset mid busyE", {31'd0, busyE}, 32'd0);
        chk("reset mid doneE", {31'd0, doneE}, 32'd0);
        chk("reset mid result", MulDivResultE, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, d);
        chk("reset no done", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
